// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared types and constants for the OAM DMA bus arbiter (DMC state under OAM_DMA_DMC_ARB_EN)
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
`ifdef OAM_DMA_DMC_ARB_EN
        ,DMC_GET
`endif
    } state_t;

    localparam logic [15:0] OAM_DMA_REG_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_REG_DEFAULT = 16'h2004;
    localparam int unsigned XFER_LEN             = 256;
    localparam logic [7:0]  LAST_CNT             = 8'(XFER_LEN - 1);

endpackage

// File: rtl/oam_dma_addr_gen.sv
// rtl/oam_dma_addr_gen.sv - OAM DMA source page/count register and get-address generator
module oam_dma_addr_gen
    import oam_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  load_page,
    input  logic        inc,
    output logic [15:0] get_addr,
    output logic        last
);

    logic [7:0] page;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page <= 8'h00;
            cnt  <= 8'h00;
        end else if (load) begin
            page <= load_page;
            cnt  <= 8'h00;
        end else if (inc) begin
            cnt  <= cnt + 8'd1;
        end
    end

    assign get_addr = {page, cnt};
    assign last     = (cnt == LAST_CNT);

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// rtl/oam_dma_bus_arbiter.sv - 2A03 external bus sequencer sharing the bus between CPU, OAM DMA and DMC
// DMC sample-fetch port is present only when OAM_DMA_DMC_ARB_EN is defined.
module oam_dma_bus_arbiter
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] OAM_DMA_REG  = OAM_DMA_REG_DEFAULT,
    parameter logic [15:0] OAM_DATA_REG = OAM_DATA_REG_DEFAULT
) (
    input  logic        CLK,
    input  logic        n_RES,
    input  logic [15:0] CPU_A,
    input  logic        CPU_RnW,
    input  logic [7:0]  CPU_DOUT,
    input  logic [7:0]  DIN,
    input  logic        DMC_REQ,
    input  logic [15:0] DMC_ADDR,
    output logic [15:0] A,
    output logic        RnW,
    output logic [7:0]  DOUT,
    output logic        RDY,
    output logic        DMC_ACK,
    output logic        BUSY
);

    state_t      state, state_next, slot_state;
    logic        parity;
    logic        oam_pend, oam_after;
    logic        dma_wr, load, inc, last;
    logic [7:0]  data_buf;
    logic [15:0] get_addr;
    logic        rdy_q, busy_q;

    oam_dma_addr_gen u_addr_gen (
        .clk       (CLK),
        .rst_n     (n_RES),
        .load      (load),
        .load_page (CPU_DOUT),
        .inc       (inc),
        .get_addr  (get_addr),
        .last      (last)
    );

`ifdef OAM_DMA_DMC_ARB_EN
    logic dmc_pend;
    logic ack_q;
    assign dmc_pend = DMC_REQ;
`else
    wire unused_dmc = &{1'b0, DMC_REQ, DMC_ADDR};
`endif

    // slot_state picks the owner of the next parity-0 get slot; DMC beats OAM
    always_comb begin
        dma_wr    = !CPU_RnW && (CPU_A == OAM_DMA_REG);
        oam_after = oam_pend && !(state == PUT && last);
`ifdef OAM_DMA_DMC_ARB_EN
        if (dmc_pend)
            slot_state = DMC_GET;
        else
`endif
        if (oam_after)
            slot_state = GET;
        else
            slot_state = IDLE;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        inc        = 1'b0;
        case (state)
            IDLE: begin
                if (dma_wr) begin
                    state_next = HALT;
                    load       = 1'b1;
                end
`ifdef OAM_DMA_DMC_ARB_EN
                else if (dmc_pend) begin
                    state_next = HALT;
                end
`endif
            end
            // the core only honours RDY on reads, so writes keep us here
            HALT: begin
                if (CPU_RnW)
                    state_next = parity ? slot_state : ALIGN;
            end
            ALIGN: state_next = slot_state;
            GET:   state_next = PUT;
            PUT: begin
                inc        = 1'b1;
                state_next = slot_state;
            end
`ifdef OAM_DMA_DMC_ARB_EN
            DMC_GET: state_next = oam_pend ? ALIGN : IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state    <= IDLE;
            parity   <= 1'b0;
            oam_pend <= 1'b0;
            data_buf <= 8'h00;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state  <= state_next;
            parity <= ~parity;
            if (load)
                oam_pend <= 1'b1;
            else if (state == PUT && last)
                oam_pend <= 1'b0;
            if (state == GET)
                data_buf <= DIN;
            rdy_q  <= (state_next == IDLE);
            busy_q <= (state_next != IDLE);
        end
    end

`ifdef OAM_DMA_DMC_ARB_EN
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES)
            ack_q <= 1'b0;
        else
            ack_q <= (state_next == DMC_GET);
    end
    assign DMC_ACK = ack_q;
`else
    assign DMC_ACK = 1'b0;
`endif

    always_comb begin
        A    = CPU_A;
        RnW  = CPU_RnW;
        DOUT = CPU_DOUT;
        case (state)
            GET: begin
                A   = get_addr;
                RnW = 1'b1;
            end
            PUT: begin
                A    = OAM_DATA_REG;
                RnW  = 1'b0;
                DOUT = data_buf;
            end
`ifdef OAM_DMA_DMC_ARB_EN
            DMC_GET: begin
                A   = DMC_ADDR;
                RnW = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign RDY  = rdy_q;
    assign BUSY = busy_q;

endmodule
